// File: rtl/mux41_rr_merge.sv
// mux41_rr_merge
//   Merges four WIDTH-bit source lanes onto one registered output lane.
//   Round-robin arbitration picks one valid lane per cycle.
//   Each output beat carries its source lane index, so a downstream 1:4
//   demux can split the stream again.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data0-3 lane data
//   in_valid   per-lane valid (bit k = lane k)
//   in_ready   per-lane accept, combinational, at most one bit high
//   out_data   registered merged data
//   out_sel    registered lane index of out_data
//   out_valid  registered, output holds a beat
//   out_ready  consumer accepts when high together with out_valid
module mux41_rr_merge #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   // The output register's valid bit is the state: EMPTY or FULL.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [1:0]         sel_q, sel_d;

   logic               load_ok;
   logic               found;
   logic [1:0]         gnt;
   logic [1:0]         idx;
   logic [WIDTH-1:0]   gnt_data;

   // A FULL register may drain and refill in the same cycle.
   assign load_ok = (state_q == EMPTY) || out_ready;

   // Scan from ptr upward (mod 4). The first valid lane wins.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr_q + i[1:0];
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   always_comb begin
      gnt_data = in_data0;
      case (gnt)
         2'd0:    gnt_data = in_data0;
         2'd1:    gnt_data = in_data1;
         2'd2:    gnt_data = in_data2;
         default: gnt_data = in_data3;
      endcase
   end

   // Gated by rst_n so that no lane handshake completes while in reset.
   always_comb begin
      in_ready = '0;
      if (rst_n && load_ok && found) begin
         in_ready[gnt] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (load_ok) begin
         if (found) begin
            state_d = FULL;
            data_d  = gnt_data;
            sel_d   = gnt;
            ptr_d   = gnt + 2'd1;
         end else begin
            // Drained with nothing to refill. data/sel keep their last value.
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux41_rr_merge.sv
// Directed bench for mux41_rr_merge. Covers reset, round-robin order,
// a single lane, backpressure, pointer wrap/skip and reset mid-stream.
module tb_mux41_rr_merge;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;
   logic             out_valid;
   logic             out_ready;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mux41_rr_merge #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [1:0] sel, input logic [3:0] data);
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " sel"},   32'(out_sel),   32'(sel));
      check({tag, " data"},  32'(out_data),  32'(data));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_data0  = 4'h1;
      in_data1  = 4'h2;
      in_data2  = 4'h3;
      in_data3  = 4'h4;
      out_ready = 1'b1;

      // Reset with every lane valid.
      tick();
      tick();
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data",  32'(out_data),  32'd0);
      check("rst out_sel",   32'(out_sel),   32'd0);
      check("rst in_ready",  32'(in_ready),  32'd0);

      // Round-robin with all lanes valid. The first grant goes to lane 0.
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         check("rr in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
         tick();
         check_out("rr", 2'(k % 4), 4'((k % 4) + 1));
      end

      // Single lane (ptr = 0).
      in_valid = 4'b0100;
      in_data2 = 4'hA;
      #1;
      check("single in_ready", 32'(in_ready), 32'b0100);
      tick();
      check_out("single", 2'd2, 4'hA);
      in_valid = 4'b0000;
      #1;
      check("idle in_ready", 32'(in_ready), 32'd0);
      tick();
      check("drain out_valid", 32'(out_valid), 32'd0);
      check("drain hold data", 32'(out_data),  32'hA);
      check("drain hold sel",  32'(out_sel),   32'd2);

      // Backpressure: hold a lane-1 beat (ptr = 3, so lane 1 is the only candidate).
      in_data1 = 4'h5;
      in_data2 = 4'h3;
      in_valid = 4'b0010;
      tick();
      check_out("bp load", 2'd1, 4'h5);
      out_ready = 1'b0;
      in_valid  = 4'b1100;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp in_ready", 32'(in_ready), 32'd0);
         tick();
         check_out("bp hold", 2'd1, 4'h5);
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(in_ready), 32'b0100);
      tick();
      check_out("bp lane2", 2'd2, 4'h3);
      check("bp next in_ready", 32'(in_ready), 32'b1000);
      tick();
      check_out("bp lane3", 2'd3, 4'h4);

      // Pointer wrapped to 0. Lane 0 is idle, so lane 1 wins over lane 3.
      in_valid = 4'b1010;
      #1;
      check("wrap in_ready", 32'(in_ready), 32'b0010);
      tick();
      check_out("wrap lane1", 2'd1, 4'h5);
      check("wrap next in_ready", 32'(in_ready), 32'b1000);

      // Reset mid-stream while a beat is held.
      out_ready = 1'b0;
      in_valid  = 4'hF;
      rst_n     = 1'b0;
      #1;
      check("mid rst in_ready", 32'(in_ready), 32'd0);
      tick();
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst out_data",  32'(out_data),  32'd0);
      check("mid rst out_sel",   32'(out_sel),   32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post rst in_ready", 32'(in_ready), 32'b0001);
      tick();
      check_out("post rst lane0", 2'd0, 4'h1);
      in_valid = 4'b0000;
      tick();
      check("final out_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
